// File: rtl/rriot_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rriot_bus_arbiter
// Brief    : Two-requester round-robin arbiter in front of a RIOT-style
//            RAM/IO device, with fixed write/read latency.
// Revision : 1.0
// ============================================================================
module rriot_bus_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              phi2,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic              req0_rs,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic              resp0_err,
    output logic [DATA_W-1:0] resp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic              req1_rs,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic              resp1_err,
    output logic [DATA_W-1:0] resp1_rdata,

    output logic              dev_we_n,
    output logic              dev_rs_n,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_di,
    input  logic [DATA_W-1:0] dev_do,
    input  logic              dev_oe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_we;
    logic                r_rs;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_pick1;
    logic                w_ready0;
    logic                w_ready1;
    logic                w_accept;
    logic                w_sel_we;
    logic                w_sel_rs;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // req1 wins when alone, or on a tie when req0 was granted last.
    assign w_pick1  = req1_valid && (!req0_valid || (r_last_grant == 1'b0));
    assign w_ready1 = !rst && (r_state == IDLE) && w_pick1;
    assign w_ready0 = !rst && (r_state == IDLE) && req0_valid && !w_pick1;
    assign w_accept = w_ready0 || w_ready1;

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;

    assign w_sel_we    = w_pick1 ? req1_we    : req0_we;
    assign w_sel_rs    = w_pick1 ? req1_rs    : req0_rs;
    assign w_sel_addr  = w_pick1 ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_pick1 ? req1_wdata : req0_wdata;

    always_ff @(posedge phi2) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_rs         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            resp0_valid  <= 1'b0;
            resp0_err    <= 1'b0;
            resp0_rdata  <= '0;
            resp1_valid  <= 1'b0;
            resp1_err    <= 1'b0;
            resp1_rdata  <= '0;
            dev_we_n     <= 1'b1;
            dev_rs_n     <= 1'b1;
            dev_addr     <= '0;
            dev_di       <= '0;
        end else begin
            resp0_valid <= 1'b0;
            resp0_err   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we         <= w_sel_we;
                        r_rs         <= w_sel_rs;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_last_grant <= w_pick1;
                        // Device pins are loaded on the accept edge so they
                        // are valid for the whole ACCESS cycle.
                        dev_we_n     <= ~w_sel_we;
                        dev_rs_n     <= ~w_sel_rs;
                        dev_addr     <= w_sel_addr;
                        dev_di       <= w_sel_wdata;
                        r_state      <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (r_we) begin
                        dev_we_n <= 1'b1;
                        dev_rs_n <= 1'b1;
                        dev_addr <= '0;
                        dev_di   <= '0;
                        if (r_last_grant) begin
                            resp1_valid <= 1'b1;
                        end else begin
                            resp0_valid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else begin
                        dev_we_n <= 1'b1;
                        dev_rs_n <= ~r_rs;
                        dev_addr <= r_addr;
                        dev_di   <= r_wdata;
                        r_state  <= DATA;
                    end
                end

                DATA: begin
                    dev_we_n <= 1'b1;
                    dev_rs_n <= 1'b1;
                    dev_addr <= '0;
                    dev_di   <= '0;
                    if (r_last_grant) begin
                        resp1_valid <= 1'b1;
                        resp1_err   <= ~dev_oe;
                        resp1_rdata <= dev_do;
                    end else begin
                        resp0_valid <= 1'b1;
                        resp0_err   <= ~dev_oe;
                        resp0_rdata <= dev_do;
                    end
                    r_state <= IDLE;
                end

                default: begin
                    dev_we_n <= 1'b1;
                    dev_rs_n <= 1'b1;
                    dev_addr <= '0;
                    dev_di   <= '0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
